// File: rtl/sys_defs.sv
// Shared definitions for the completion stage: CDB/lane sizing constants,
// the execute packet carried from the FU lanes to the CDB, and the
// per-lane stall threshold rule.
package sys_defs;

    localparam int CDB_WIDTH    = 3;
    localparam int LANE_DEPTH   = 4;
    localparam int MULT_LANE    = 4;
    localparam int MULT_LATENCY = 2;

    localparam int XLEN     = 32;
    localparam int PRN_BITS = 6;
    localparam int ROB_BITS = 5;

    typedef struct packed {
        logic                packet_valid;
        logic [XLEN-1:0]     result;
        logic [PRN_BITS-1:0] dest_prn;
        logic [ROB_BITS-1:0] rob_entry;
    } EXECUTE_PACKET;

    // Occupancy at which a lane must stall issue. The pipelined multiplier
    // keeps MULT_LATENCY more packets in flight, so it stalls that much earlier.
    function automatic int stall_threshold(input int lane, input int mult_lane,
                                           input int depth, input int mult_latency);
        return (lane == mult_lane) ? depth - 1 - mult_latency : depth - 1;
    endfunction

endpackage

// File: rtl/lane_fifo.sv
// Per-lane completion buffer: circular storage with head/tail pointers and an
// explicit occupancy count. Pushing into a full lane is only accepted when the
// head pops on the same edge; otherwise the packet is dropped and flagged.
module lane_fifo
    import sys_defs::*;
#(
    parameter int DEPTH    = LANE_DEPTH,
    parameter int CNT_BITS = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  EXECUTE_PACKET       in_pkt,
    input  logic                pop,
    output EXECUTE_PACKET       head_pkt,
    output logic                empty,
    output logic [CNT_BITS-1:0] count_next
);

    localparam int PTR_BITS = $clog2(DEPTH);

    EXECUTE_PACKET       mem [0:DEPTH-1];
    logic [PTR_BITS-1:0] head;
    logic [PTR_BITS-1:0] tail;
    logic [CNT_BITS-1:0] count;
    logic                full;
    logic                push;
    logic                do_pop;

    // Occupancy flags, accepted push/pop and the post-edge count.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
        full       = (count == CNT_BITS'(DEPTH));
        empty      = (count == '0);
        do_pop     = pop && !empty;
        push       = in_pkt.packet_valid && (!full || do_pop);
        count_next = count + CNT_BITS'(push) - CNT_BITS'(do_pop);
        head_pkt   = mem[head];
    end

    // Pointer and count state; flush and reset both empty the lane.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + PTR_BITS'(1);
            if (do_pop)
                head <= head + PTR_BITS'(1);
            count <= count_next;
        end
    end

    // Storage write; when full with a same-edge pop, tail aliases the slot being vacated.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the count decides which entries are meaningful.
        if (push && !(rst || flush))
            mem[tail] <= in_pkt;
    end

    // A well-behaved issue stage never pushes into a full lane that is not popping.
    overflow_check: assert property (@(posedge clk) disable iff (rst || flush)
                                     !(in_pkt.packet_valid && full && !do_pop));

endmodule

// File: rtl/complete_arbiter.sv
// Completion-stage arbiter: buffers up to ISSUE_WIDTH FU results per cycle in
// per-lane FIFOs, grants up to CDB_WIDTH lane heads per cycle in round-robin
// order onto a registered CDB, and produces registered per-lane stalls.
module complete_arbiter #(
    parameter int ISSUE_WIDTH  = 7,
    parameter int CDB_WIDTH    = sys_defs::CDB_WIDTH,
    parameter int LANE_DEPTH   = sys_defs::LANE_DEPTH,
    parameter int MULT_LANE    = sys_defs::MULT_LANE,
    parameter int MULT_LATENCY = sys_defs::MULT_LATENCY
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pipe_flush,
    input  sys_defs::EXECUTE_PACKET execute_pkt [0:ISSUE_WIDTH-1],
    output logic [ISSUE_WIDTH-1:0]  lane_stall,
    output sys_defs::EXECUTE_PACKET cdb_pkt     [0:CDB_WIDTH-1]
);

    localparam int LANE_BITS = $clog2(ISSUE_WIDTH);
    localparam int SLOT_BITS = $clog2(CDB_WIDTH + 1);
    localparam int CNT_BITS  = $clog2(LANE_DEPTH) + 1;
    localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(ISSUE_WIDTH - 1);

    sys_defs::EXECUTE_PACKET head_pkt  [0:ISSUE_WIDTH-1];
    sys_defs::EXECUTE_PACKET cdb_next  [0:CDB_WIDTH-1];
    logic [CNT_BITS-1:0]     count_next [0:ISSUE_WIDTH-1];
    logic [ISSUE_WIDTH-1:0]  lane_empty;
    logic [ISSUE_WIDTH-1:0]  grant;
    logic [ISSUE_WIDTH-1:0]  stall_next;
    logic [LANE_BITS-1:0]    rr_ptr;
    logic [LANE_BITS-1:0]    rr_next;
    logic [LANE_BITS-1:0]    scan_lane;
    logic [SLOT_BITS-1:0]    slot;
    logic                    clear;

    assign clear = rst || pipe_flush;

    for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_lane
        localparam int THRESH = sys_defs::stall_threshold(g, MULT_LANE, LANE_DEPTH, MULT_LATENCY);

        lane_fifo #(
            .DEPTH    (LANE_DEPTH),
            .CNT_BITS (CNT_BITS)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .flush      (pipe_flush),
            .in_pkt     (execute_pkt[g]),
            .pop        (grant[g]),
            .head_pkt   (head_pkt[g]),
            .empty      (lane_empty[g]),
            .count_next (count_next[g])
        );

        // Stall leaves room for the packets issue can still have in flight to this lane.
        assign stall_next[g] = (count_next[g] >= CNT_BITS'(THRESH));
    end

    // Round-robin scan from rr_ptr: the first CDB_WIDTH non-empty lanes fill slots in order.
    always_comb begin
        grant     = '0;
        rr_next   = rr_ptr;
        scan_lane = rr_ptr;
        slot      = '0;
        for (int s = 0; s < CDB_WIDTH; s++)
            cdb_next[s] = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (!lane_empty[scan_lane] && slot < SLOT_BITS'(CDB_WIDTH)) begin
                grant[scan_lane] = 1'b1;
                cdb_next[slot]   = head_pkt[scan_lane];
                slot             = slot + SLOT_BITS'(1);
                rr_next          = (scan_lane == LAST_LANE) ? '0 : scan_lane + LANE_BITS'(1);
            end
            scan_lane = (scan_lane == LAST_LANE) ? '0 : scan_lane + LANE_BITS'(1);
        end
    end

    // CDB, stall and round-robin registers; reset and flush squash everything in flight.
    always_ff @(posedge clk) begin
        if (clear) begin
            rr_ptr     <= '0;
            lane_stall <= '0;
            for (int s = 0; s < CDB_WIDTH; s++)
                cdb_pkt[s] <= '0;
        end else begin
            rr_ptr     <= rr_next;
            lane_stall <= stall_next;
            for (int s = 0; s < CDB_WIDTH; s++)
                cdb_pkt[s] <= cdb_next[s];
        end
    end

endmodule

// File: tb/tb_complete_arbiter.sv
// Directed bench for complete_arbiter. A small queue-style reference model
// runs alongside the directed vectors and is compared every cycle.
module tb_complete_arbiter;
    import sys_defs::*;

    localparam int IW    = 7;
    localparam int CW    = 3;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          pipe_flush;
    EXECUTE_PACKET drive   [0:IW-1];
    logic [IW-1:0] lane_stall;
    EXECUTE_PACKET cdb_pkt [0:CW-1];

    always #5 clk = ~clk;

    complete_arbiter #(
        .ISSUE_WIDTH  (IW),
        .CDB_WIDTH    (CW),
        .LANE_DEPTH   (DEPTH),
        .MULT_LANE    (4),
        .MULT_LATENCY (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_flush  (pipe_flush),
        .execute_pkt (drive),
        .lane_stall  (lane_stall),
        .cdb_pkt     (cdb_pkt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic EXECUTE_PACKET mk(input logic [31:0] r, input logic [5:0] p, input logic [4:0] rob);
        EXECUTE_PACKET x;
        x.packet_valid = 1'b1;
        x.result       = r;
        x.dest_prn     = p;
        x.rob_entry    = rob;
        return x;
    endfunction

    // Reference model: per-lane shift buffers, pop-before-push each edge.
    EXECUTE_PACKET mbuf [0:IW-1][0:DEPTH-1];
    int            mcnt [0:IW-1];
    int            m_rr = 0;
    EXECUTE_PACKET m_cdb [0:CW-1];
    logic [IW-1:0] m_stall = '0;
    int            m_ovf = 0;

    task automatic model_edge();
        EXECUTE_PACKET ncdb [0:CW-1];
        int n, l, last;
        if (rst || pipe_flush) begin
            for (int i = 0; i < IW; i++) mcnt[i] = 0;
            for (int s = 0; s < CW; s++) m_cdb[s] = '0;
            m_rr    = 0;
            m_stall = '0;
            return;
        end
        for (int s = 0; s < CW; s++) ncdb[s] = '0;
        n    = 0;
        last = -1;
        for (int k = 0; k < IW; k++) begin
            l = (m_rr + k) % IW;
            if (mcnt[l] > 0 && n < CW) begin
                ncdb[n] = mbuf[l][0];
                for (int j = 0; j < DEPTH - 1; j++) mbuf[l][j] = mbuf[l][j+1];
                mcnt[l]--;
                n++;
                last = l;
            end
        end
        for (int i = 0; i < IW; i++) begin
            if (drive[i].packet_valid) begin
                if (mcnt[i] < DEPTH) begin
                    mbuf[i][mcnt[i]] = drive[i];
                    mcnt[i]++;
                end else begin
                    m_ovf++;
                end
            end
        end
        if (last >= 0) m_rr = (last + 1) % IW;
        for (int i = 0; i < IW; i++) m_stall[i] = (mcnt[i] >= ((i == 4) ? 1 : 3));
        for (int s = 0; s < CW; s++) m_cdb[s] = ncdb[s];
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        for (int s = 0; s < CW; s++)
            check($sformatf("mdl_cdb%0d", s), 64'(cdb_pkt[s]), 64'(m_cdb[s]));
        check("mdl_stall", 64'(lane_stall), 64'(m_stall));
    endtask

    task automatic clear_drive();
        for (int i = 0; i < IW; i++) drive[i] = '0;
    endtask

    task automatic expect_idle(input string tag);
        for (int s = 0; s < CW; s++)
            check($sformatf("%s_slot%0d", tag, s), 64'(cdb_pkt[s]), 64'(0));
        check($sformatf("%s_stall", tag), 64'(lane_stall), 64'(0));
    endtask

    logic prev0, saw0_on, saw0_off, saw4_on;

    initial begin
        for (int i = 0; i < IW; i++) mcnt[i] = 0;
        for (int s = 0; s < CW; s++) m_cdb[s] = '0;
        rst        = 1'b1;
        pipe_flush = 1'b0;
        clear_drive();

        // Reset then idle.
        step();
        step();
        rst = 1'b0;
        repeat (5) step();
        expect_idle("idle");

        // Single packet on lane 2: two-cycle latency, fields unchanged.
        drive[2] = mk(32'h1234, 6'd9, 5'd3);
        step();
        clear_drive();
        check("single_n1_slot0_valid", 64'(cdb_pkt[0].packet_valid), 64'(0));
        step();
        check("single_slot0", 64'(cdb_pkt[0]), 64'(mk(32'h1234, 6'd9, 5'd3)));
        check("single_slot1_valid", 64'(cdb_pkt[1].packet_valid), 64'(0));
        check("single_slot2_valid", 64'(cdb_pkt[2].packet_valid), 64'(0));
        step();

        // One-cycle flush returns rr_ptr to 0 before the burst.
        pipe_flush = 1'b1;
        step();
        pipe_flush = 1'b0;

        // Full burst on all lanes.
        for (int i = 0; i < IW; i++) drive[i] = mk(32'h100 + 32'(i), 6'(i + 10), 5'(i));
        step();
        clear_drive();
        check("burst_stall_n1", 64'(lane_stall), 64'(7'b0010000));
        step();
        for (int s = 0; s < 3; s++)
            check($sformatf("burst_n2_slot%0d", s), 64'(cdb_pkt[s]), 64'(mk(32'h100 + 32'(s), 6'(s + 10), 5'(s))));
        check("burst_stall_n2", 64'(lane_stall), 64'(7'b0010000));
        step();
        for (int s = 0; s < 3; s++)
            check($sformatf("burst_n3_slot%0d", s), 64'(cdb_pkt[s]), 64'(mk(32'h103 + 32'(s), 6'(s + 13), 5'(s + 3))));
        check("burst_stall_n3", 64'(lane_stall), 64'(0));
        step();
        check("burst_n4_slot0", 64'(cdb_pkt[0]), 64'(mk(32'h106, 6'd16, 5'd6)));
        check("burst_n4_slot1_valid", 64'(cdb_pkt[1].packet_valid), 64'(0));
        check("burst_n4_slot2_valid", 64'(cdb_pkt[2].packet_valid), 64'(0));
        step();
        expect_idle("burst_n5");

        // rr_ptr back at 0: lane 0 must win slot 0 over lane 6.
        drive[6] = mk(32'hA6, 6'd6, 5'd16);
        drive[0] = mk(32'hA0, 6'd1, 5'd10);
        step();
        clear_drive();
        step();
        check("rr_wrap_slot0", 64'(cdb_pkt[0]), 64'(mk(32'hA0, 6'd1, 5'd10)));
        check("rr_wrap_slot1", 64'(cdb_pkt[1]), 64'(mk(32'hA6, 6'd6, 5'd16)));
        check("rr_wrap_slot2_valid", 64'(cdb_pkt[2].packet_valid), 64'(0));
        step();

        // Backpressure: every lane fed whenever its stall is low.
        prev0    = 1'b0;
        saw0_on  = 1'b0;
        saw0_off = 1'b0;
        saw4_on  = 1'b0;
        for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < IW; i++)
                drive[i] = lane_stall[i] ? '0 : mk(32'h2000 + 32'(c * 8 + i), 6'(i), 5'(c));
            step();
            if (lane_stall[0] && !prev0) saw0_on = 1'b1;
            if (!lane_stall[0] && prev0 && saw0_on) saw0_off = 1'b1;
            if (lane_stall[4]) saw4_on = 1'b1;
            prev0 = lane_stall[0];
        end
        clear_drive();
        check("bp_stall0_asserted", 64'(saw0_on), 64'(1));
        check("bp_stall0_released", 64'(saw0_off), 64'(1));
        check("bp_stall4_asserted", 64'(saw4_on), 64'(1));
        check("bp_model_overflow", 64'(m_ovf), 64'(0));
        repeat (14) step();
        expect_idle("drain");

        // Flush with lanes partly full and new packets arriving.
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < IW; i++)
                drive[i] = lane_stall[i] ? '0 : mk(32'h4000 + 32'(c * 8 + i), 6'(i), 5'(c));
            step();
        end
        for (int i = 0; i < IW; i++) drive[i] = mk(32'hDEAD0000 + 32'(i), 6'(i), 5'(i));
        pipe_flush = 1'b1;
        step();
        pipe_flush = 1'b0;
        clear_drive();
        expect_idle("flush_n1");
        for (int c = 0; c < 4; c++) begin
            step();
            for (int s = 0; s < CW; s++)
                check($sformatf("flush_after%0d_slot%0d_valid", c, s), 64'(cdb_pkt[s].packet_valid), 64'(0));
        end

        // Reset while the CDB is carrying three valid slots.
        for (int i = 0; i < IW; i++) drive[i] = mk(32'h3000 + 32'(i), 6'(i), 5'(i));
        step();
        clear_drive();
        step();
        for (int s = 0; s < CW; s++)
            check($sformatf("mid_burst_slot%0d", s), 64'(cdb_pkt[s]), 64'(mk(32'h3000 + 32'(s), 6'(s), 5'(s))));
        for (int i = 0; i < IW; i++) drive[i] = mk(32'hBEEF0000 + 32'(i), 6'(i), 5'(i));
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_drive();
        expect_idle("rst_mid_n1");
        step();
        expect_idle("rst_mid_n2");
        step();
        expect_idle("rst_mid_n3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/complete_arbiter.md
# complete_arbiter

Completion-stage arbiter directly downstream of the functional-unit block. Each cycle it accepts up to `ISSUE_WIDTH` execute packets, one per FU lane, and buffers each lane in a small FIFO. It then grants up to `CDB_WIDTH` lane heads onto the common data bus (CDB) in round-robin order. Registered per-lane stall outputs throttle issue before any lane FIFO overflows.

## Interface
Parameters:
- `ISSUE_WIDTH`, 7: number of FU lanes.
- `CDB_WIDTH`, 3: CDB slots per cycle.
- `LANE_DEPTH`, 4: entries per lane FIFO (power of two).
- `MULT_LANE`, 4: index of the pipelined multiplier lane.
- `MULT_LATENCY`, 2: multiplier pipeline depth in cycles.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `pipe_flush`  in  1: synchronous squash of all buffered and arriving work.
- `execute_pkt`  in  EXECUTE_PACKET [0:ISSUE_WIDTH-1]: per-lane FU results. A lane carries work only when its `packet_valid` is 1.
- `lane_stall`  out  [ISSUE_WIDTH-1:0]: registered. 1 means issue must not dispatch to that lane next cycle.
- `cdb_pkt`  out  EXECUTE_PACKET [0:CDB_WIDTH-1]: registered CDB broadcast. A slot is valid when its `packet_valid` is 1.

## Operation
- **Enqueue:** a lane with `packet_valid`=1 is written at its FIFO tail. Invalid packets are ignored.
- **Grant:** scan lanes starting at `rr_ptr`, wrapping modulo `ISSUE_WIDTH`. The first `CDB_WIDTH` non-empty lanes are granted, one entry each. Slot 0 receives the first granted lane, slot 1 the second, and so on. Unused slots carry `packet_valid`=0.
- **Pop:** each granted lane pops its head on the same edge that `cdb_pkt` is loaded.
- **rr_ptr update:** becomes (last granted lane + 1) mod `ISSUE_WIDTH`. It is unchanged when nothing is granted.
- **Count:** per-lane `count_next` = count + enq − deq. Simultaneous enqueue and dequeue on a full lane is legal and leaves count at `LANE_DEPTH`.
- **Stall threshold:** T_i = `LANE_DEPTH`−1, minus `MULT_LATENCY` when i==`MULT_LANE`.
- **Stall output:** `lane_stall[i]` is registered from (`count_next[i]` >= T_i). With defaults, ordinary lanes stall at 3 entries and the multiplier lane at 1.
- **Overflow:** an enqueue into a full lane with no dequeue is an overflow. An assertion fires and the packet is dropped. A correct issue stage never causes this.
- **Flush/reset:** `pipe_flush` or `rst` clears all counts and pointers, sets `rr_ptr`=0, forces every `cdb_pkt` slot to `packet_valid`=0 (other fields zero), and sets `lane_stall` to 0. Packets arriving in that cycle are discarded. `rst` takes priority; both have the same effect.
- **Pass-through:** packet fields are carried unchanged, with no modification of result, `dest_prn` or `rob_entry`.

## Timing
- **Latency:** a packet presented in cycle N is written at the end of N, may be granted in N+1, and appears on `cdb_pkt` in N+2. Minimum latency is 2 cycles; there is no bypass.
- **Stall response:** `lane_stall` reflects occupancy after edge N. Issue observes it in N+1.
- **Absorption:** thresholds absorb one in-flight packet per ordinary lane, and 1+`MULT_LATENCY` for the multiplier lane.
- **Starvation bound:** any non-empty lane is granted within ceil(`ISSUE_WIDTH`/`CDB_WIDTH`) = 3 cycles.
- **Reset values:** `cdb_pkt` all zero, `lane_stall` all 0.

## Structure
- The shared package (sys_defs) holds the `CDB_WIDTH`, `LANE_DEPTH`, `MULT_LANE` and `MULT_LATENCY` constants; `EXECUTE_PACKET` is already defined there.
- Sub-module `lane_fifo`: circular buffer with head/tail pointers and an explicit count. Instantiated once per lane via generate.
- The arbiter itself contains the round-robin grant logic, the `rr_ptr`, the stall registers and the `cdb_pkt` registers.

## Test plan
- **Reset/idle:** reset, then idle 5 cycles → every `cdb_pkt` `packet_valid`=0, `lane_stall`=0.
- **Single packet:** valid packet on lane 2 (result 0x1234, `dest_prn` 9) in cycle 10 → appears on `cdb_pkt[0]` in cycle 12 with identical fields; slots 1 and 2 invalid.
- **Full burst:** all 7 lanes valid in one cycle, `rr_ptr`=0 → granted lanes {0,1,2} in cycle +2, {3,4,5} in cycle +3, {6} in cycle +4; `rr_ptr` ends at 0.
- **Backpressure:** lane 0 fed continuously while lanes 1–6 are also fed to saturate the CDB → `lane_stall[0]` asserts at count 3 and deasserts when count falls below 3; `lane_stall[4]` asserts at count 1; no overflow assertion ever fires.
- **Flush:** lanes hold 2–3 entries each, assert `pipe_flush` for 1 cycle with new valid packets arriving → next cycle all CDB slots invalid, stalls 0; the arriving packets never appear.
- **Reset mid-burst:** assert `rst` while `cdb_pkt` holds 3 valid slots → all state cleared on that edge, output zero the following cycle.
